// File: rtl/digger_motion.sv
// -----------------------------------------------------------------------------
// digger_motion
//
// Tile-grid movement controller for the digger sprite. One step is taken per
// video frame. frame_clk comes from another clock domain, so it is brought in
// through a two-flop synchronizer and turned into a one-cycle tick. On each
// tick the current keycode decides whether the digger moves, in which
// direction, and whether a requested turn can happen yet. A perpendicular turn
// is only allowed when the sprite sits exactly on a 16-pixel grid line of its
// current travel axis, which keeps it inside the tunnels.
//
// Parameters
//   STEP     pixels per tick (1, 2, 4 or 8)
//   START_X  X position after reset (must be a multiple of 16)
//   START_Y  Y position after reset (must be a multiple of 16)
//
// Ports
//   Clk         system clock
//   Reset       asynchronous, active-low reset
//   frame_clk   vertical-sync level signal, asynchronous to Clk
//   keycode     HID keycode: 0x1A up, 0x16 down, 0x04 left, 0x07 right
//   Ball_X_Loc  sprite top-left X in pixels (registered)
//   Ball_Y_Loc  sprite top-left Y in pixels (registered)
//   facing      direction: 00 up, 01 down, 10 left, 11 right (registered)
//   is_moving   high while the controller is in its MOVE state
//   step_pulse  one-cycle pulse whenever the position changes
// -----------------------------------------------------------------------------
module digger_motion #(
    parameter int unsigned STEP    = 2,
    parameter logic [9:0]  START_X = 10'd240,
    parameter logic [9:0]  START_Y = 10'd96
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] Ball_X_Loc,
    output logic [9:0] Ball_Y_Loc,
    output logic [1:0] facing,
    output logic       is_moving,
    output logic       step_pulse
);

    // Playfield is 32x24 tiles of 16 px; the top 96 rows are the score area.
    localparam logic [9:0] X_MAX  = 10'd496;
    localparam logic [9:0] Y_MIN  = 10'd96;
    localparam logic [9:0] Y_MAX  = 10'd464;
    localparam logic [9:0] STEP_V = 10'(STEP);

    // Thresholds precomputed so every bound test happens before the add or
    // subtract, never by looking at a wrapped result.
    localparam logic [9:0] X_RIGHT_LIMIT = X_MAX - STEP_V;
    localparam logic [9:0] Y_DOWN_LIMIT  = Y_MAX - STEP_V;
    localparam logic [9:0] Y_UP_LIMIT    = Y_MIN + STEP_V;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    state_t state_reg;

    // -------------------------------------------------------------------------
    // frame_clk synchronizer and rising-edge tick
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg;      // [0] first flop, [1] synchronized level
    logic       sync_prev_reg; // synchronized level one cycle earlier
    logic [1:0] primed_reg;    // marks when sync_reg[1] holds a real sample
    logic       armed_reg;     // set once the synchronized level is seen low
    logic       tick;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_reg      <= 2'b00;
            sync_prev_reg <= 1'b0;
            primed_reg    <= 2'b00;
            armed_reg     <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], frame_clk};
            sync_prev_reg <= sync_reg[1];
            primed_reg    <= {primed_reg[0], 1'b1};
            // The flops come out of reset at 0, so a frame_clk that is already
            // high at release would look like a rising edge. Edges are only
            // honoured after the synchronized level has genuinely been low.
            if (primed_reg[1] && !sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign tick = sync_reg[1] & ~sync_prev_reg & armed_reg;

    // -------------------------------------------------------------------------
    // Key decode
    // -------------------------------------------------------------------------
    logic       key_valid;
    logic [1:0] key_dir;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_RIGHT;
        case (keycode)
            KEY_W:   key_dir = DIR_UP;
            KEY_S:   key_dir = DIR_DOWN;
            KEY_A:   key_dir = DIR_LEFT;
            KEY_D:   key_dir = DIR_RIGHT;
            default: key_valid = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Direction arbitration
    // facing[1] is 1 for the horizontal directions, so comparing bit 1 of two
    // directions tells whether they share an axis.
    // -------------------------------------------------------------------------
    logic       travel_horiz;
    logic       same_axis;
    logic       aligned;
    logic [1:0] next_dir;

    always_comb begin
        travel_horiz = facing[1];
        same_axis    = (facing[1] == key_dir[1]);
        // Alignment is judged on the current travel axis: a horizontal mover
        // may turn vertical only when it sits on a column boundary, and vice
        // versa.
        if (travel_horiz) begin
            aligned = (Ball_X_Loc[3:0] == 4'd0);
        end else begin
            aligned = (Ball_Y_Loc[3:0] == 4'd0);
        end
        // Same direction and reversals take effect at once; perpendicular
        // requests wait for the grid line and keep the old heading until then.
        if (same_axis || aligned) begin
            next_dir = key_dir;
        end else begin
            next_dir = facing;
        end
    end

    // -------------------------------------------------------------------------
    // Clamped step along next_dir
    // -------------------------------------------------------------------------
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       pos_change;

    always_comb begin
        x_next = Ball_X_Loc;
        y_next = Ball_Y_Loc;
        case (next_dir)
            DIR_UP: begin
                if (Ball_Y_Loc < Y_UP_LIMIT) begin
                    y_next = Y_MIN;
                end else begin
                    y_next = Ball_Y_Loc - STEP_V;
                end
            end
            DIR_DOWN: begin
                if (Ball_Y_Loc > Y_DOWN_LIMIT) begin
                    y_next = Y_MAX;
                end else begin
                    y_next = Ball_Y_Loc + STEP_V;
                end
            end
            DIR_LEFT: begin
                // Left edge is 0, so anything closer than one step clamps.
                if (Ball_X_Loc < STEP_V) begin
                    x_next = 10'd0;
                end else begin
                    x_next = Ball_X_Loc - STEP_V;
                end
            end
            default: begin
                if (Ball_X_Loc > X_RIGHT_LIMIT) begin
                    x_next = X_MAX;
                end else begin
                    x_next = Ball_X_Loc + STEP_V;
                end
            end
        endcase
        pos_change = (x_next != Ball_X_Loc) || (y_next != Ball_Y_Loc);
    end

    // -------------------------------------------------------------------------
    // Movement FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg  <= ST_IDLE;
            Ball_X_Loc <= START_X;
            Ball_Y_Loc <= START_Y;
            facing     <= DIR_RIGHT;
            is_moving  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (tick) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (key_valid) begin
                            state_reg  <= ST_MOVE;
                            is_moving  <= 1'b1;
                            facing     <= next_dir;
                            Ball_X_Loc <= x_next;
                            Ball_Y_Loc <= y_next;
                            step_pulse <= pos_change;
                        end
                    end
                    ST_MOVE: begin
                        if (key_valid) begin
                            // Stays in MOVE even when clamped against a bound.
                            facing     <= next_dir;
                            Ball_X_Loc <= x_next;
                            Ball_Y_Loc <= y_next;
                            step_pulse <= pos_change;
                        end else begin
                            // Releasing the key stops without a final step.
                            state_reg <= ST_IDLE;
                            is_moving <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        is_moving <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digger_motion.sv
module tb_digger_motion;

    localparam int STEP = 2;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] Ball_X_Loc;
    logic [9:0] Ball_Y_Loc;
    logic [1:0] facing;
    logic       is_moving;
    logic       step_pulse;

    digger_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .Ball_X_Loc (Ball_X_Loc),
        .Ball_Y_Loc (Ball_Y_Loc),
        .facing     (facing),
        .is_moving  (is_moving),
        .step_pulse (step_pulse)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int asserts = 0;
    int fails   = 0;

    // Reference model: position as plain integers, direction 0 up, 1 down,
    // 2 left, 3 right.
    int mx, my, mface;
    bit mmov, m_moved;

    // Results of the last frame pulse.
    int tk_pulses, tk_first;

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        mx = 240; my = 96; mface = 3; mmov = 0; m_moved = 0;
    endtask

    task automatic model_tick(input logic [7:0] k);
        int req, nd, nx, ny;
        bit along_x, req_x, on_grid;
        req = key_dir(k);
        m_moved = 0;
        if (req < 0) begin
            mmov = 0;
            return;
        end
        mmov    = 1;
        along_x = (mface >= 2);
        req_x   = (req >= 2);
        on_grid = along_x ? (mx % 16 == 0) : (my % 16 == 0);
        nd = (along_x == req_x || on_grid) ? req : mface;
        nx = mx;
        ny = my;
        case (nd)
            0:       ny = my - STEP;
            1:       ny = my + STEP;
            2:       nx = mx - STEP;
            default: nx = mx + STEP;
        endcase
        if (nx < 0)   nx = 0;
        if (nx > 496) nx = 496;
        if (ny < 96)  ny = 96;
        if (ny > 464) ny = 464;
        m_moved = (nx != mx) || (ny != my);
        mface = nd;
        mx = nx;
        my = ny;
    endtask

    // One frame: frame_clk rises at a falling Clk edge with the key applied,
    // stays high 6 cycles, then low 4 cycles. Records pulses and the cycle
    // (counted from the rise) on which the first step_pulse is seen.
    task automatic pulse_frame(input logic [7:0] k);
        @(negedge Clk);
        keycode   = k;
        frame_clk = 1'b1;
        tk_pulses = 0;
        tk_first  = -1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 7) begin
                @(negedge Clk);
                frame_clk = 1'b0;
            end
            @(posedge Clk);
            #1;
            if (step_pulse === 1'b1) begin
                tk_pulses++;
                if (tk_first < 0) tk_first = c;
            end
        end
        $display("tick key=%h x=%0d y=%0d facing=%b moving=%b pulses=%0d",
                 k, Ball_X_Loc, Ball_Y_Loc, facing, is_moving, tk_pulses);
    endtask

    task automatic do_reset();
        Reset     = 1'b0;
        keycode   = 8'h00;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        Reset     = 1'b0;
        keycode   = 8'h07;
        frame_clk = 1'b0;
        #12;
        asserts++;
        if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving, step_pulse} !== {10'd240, 10'd96, 2'b11, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got x=%0d y=%0d f=%b mv=%b sp=%b, expected 240 96 11 0 0",
                     Ball_X_Loc, Ball_Y_Loc, facing, is_moving, step_pulse);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk);
            #1;
            asserts++;
            if (step_pulse !== 1'b0 || Ball_X_Loc !== 10'd240 || is_moving !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got x=%0d mv=%b sp=%b, expected 240 0 0",
                         c, Ball_X_Loc, is_moving, step_pulse);
            end
        end
        model_reset();
    endtask

    task automatic test_walk_right();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            pulse_frame(8'h07);
            model_tick(8'h07);
            asserts++;
            if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving} !== {10'(240 + 2 * i), 10'd96, 2'b11, 1'b1}) begin
                fails++;
                $display("FAIL walk step %0d: got x=%0d y=%0d f=%b mv=%b, expected x=%0d y=96 f=11 mv=1",
                         i, Ball_X_Loc, Ball_Y_Loc, facing, is_moving, 240 + 2 * i);
            end
            asserts++;
            if (tk_pulses !== 1 || tk_first !== 3) begin
                fails++;
                $display("FAIL walk pulse %0d: got pulses=%0d at cycle %0d, expected 1 at cycle 3",
                         i, tk_pulses, tk_first);
            end
        end
    endtask

    task automatic test_turn_unaligned();
        do_reset();
        pulse_frame(8'h07); model_tick(8'h07);
        pulse_frame(8'h07); model_tick(8'h07);
        for (int i = 0; i < 7; i++) begin
            pulse_frame(8'h16);
            model_tick(8'h16);
            asserts++;
            if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving} !== {10'(mx), 10'(my), 2'(mface), mmov}) begin
                fails++;
                $display("FAIL turn tick %0d: got x=%0d y=%0d f=%b mv=%b, expected x=%0d y=%0d f=%0d mv=%0d",
                         i, Ball_X_Loc, Ball_Y_Loc, facing, is_moving, mx, my, mface, mmov);
            end
            asserts++;
            if (tk_pulses !== int'(m_moved) || (m_moved && tk_first !== 3)) begin
                fails++;
                $display("FAIL turn pulse %0d: got pulses=%0d at cycle %0d, expected %0d at cycle 3",
                         i, tk_pulses, tk_first, m_moved);
            end
        end
        asserts++;
        if ({Ball_X_Loc, Ball_Y_Loc, facing} !== {10'd256, 10'd98, 2'b01}) begin
            fails++;
            $display("FAIL turn_final: got x=%0d y=%0d f=%b, expected x=256 y=98 f=01",
                     Ball_X_Loc, Ball_Y_Loc, facing);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_frame(8'h07);
            model_tick(8'h07);
        end
        asserts++;
        if (Ball_X_Loc !== 10'd250) begin
            fails++;
            $display("FAIL reverse_setup: got x=%0d, expected 250", Ball_X_Loc);
        end
        pulse_frame(8'h04);
        model_tick(8'h04);
        asserts++;
        if ({Ball_X_Loc, facing, is_moving} !== {10'd248, 2'b10, 1'b1} || tk_pulses !== 1) begin
            fails++;
            $display("FAIL reverse: got x=%0d f=%b mv=%b pulses=%0d, expected x=248 f=10 mv=1 pulses=1",
                     Ball_X_Loc, facing, is_moving, tk_pulses);
        end
    endtask

    task automatic test_bounds();
        logic [7:0] k;
        do_reset();
        // Right to the edge, then left to 0, then down to the bottom, each
        // followed by one extra tick that must be clamped.
        for (int leg = 0; leg < 3; leg++) begin
            k = (leg == 0) ? 8'h07 : (leg == 1) ? 8'h04 : 8'h16;
            for (int guard = 0; guard < 300; guard++) begin
                pulse_frame(k);
                model_tick(k);
                asserts++;
                if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving} !== {10'(mx), 10'(my), 2'(mface), mmov}
                    || tk_pulses !== int'(m_moved)) begin
                    fails++;
                    $display("FAIL bounds leg %0d: got x=%0d y=%0d f=%b mv=%b p=%0d, expected x=%0d y=%0d f=%0d mv=%0d p=%0d",
                             leg, Ball_X_Loc, Ball_Y_Loc, facing, is_moving, tk_pulses, mx, my, mface, mmov, m_moved);
                end
                if (!m_moved) break;
            end
            asserts++;
            if (tk_pulses !== 0 || is_moving !== 1'b1) begin
                fails++;
                $display("FAIL bounds_block leg %0d: got pulses=%0d mv=%b, expected 0 1",
                         leg, tk_pulses, is_moving);
            end
            if (leg == 0) begin
                asserts++;
                if (Ball_X_Loc !== 10'd496) begin
                    fails++;
                    $display("FAIL bounds_right: got x=%0d, expected 496", Ball_X_Loc);
                end
                // At the top row: an up request turns but cannot move.
                pulse_frame(8'h1A);
                model_tick(8'h1A);
                asserts++;
                if ({Ball_Y_Loc, facing, is_moving} !== {10'd96, 2'b00, 1'b1} || tk_pulses !== 0) begin
                    fails++;
                    $display("FAIL bounds_top: got y=%0d f=%b mv=%b p=%0d, expected y=96 f=00 mv=1 p=0",
                             Ball_Y_Loc, facing, is_moving, tk_pulses);
                end
            end else if (leg == 1) begin
                asserts++;
                if (Ball_X_Loc !== 10'd0) begin
                    fails++;
                    $display("FAIL bounds_left: got x=%0d, expected 0", Ball_X_Loc);
                end
            end else begin
                asserts++;
                if (Ball_Y_Loc !== 10'd464) begin
                    fails++;
                    $display("FAIL bounds_bottom: got y=%0d, expected 464", Ball_Y_Loc);
                end
            end
        end
    endtask

    task automatic test_stop_and_glitch();
        do_reset();
        pulse_frame(8'h07); model_tick(8'h07);
        pulse_frame(8'h07); model_tick(8'h07);
        pulse_frame(8'h00); model_tick(8'h00);
        asserts++;
        if ({Ball_X_Loc, is_moving} !== {10'(mx), 1'b0} || tk_pulses !== 0) begin
            fails++;
            $display("FAIL stop: got x=%0d mv=%b p=%0d, expected x=%0d mv=0 p=0",
                     Ball_X_Loc, is_moving, tk_pulses, mx);
        end
        // Keys wiggling between frames must do nothing.
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            keycode = (c % 2 == 0) ? 8'h07 : 8'(($urandom));
            @(posedge Clk);
            #1;
            asserts++;
            if (step_pulse !== 1'b0 || Ball_X_Loc !== 10'(mx) || is_moving !== 1'b0) begin
                fails++;
                $display("FAIL glitch cycle %0d: got x=%0d mv=%b sp=%b, expected x=%0d mv=0 sp=0",
                         c, Ball_X_Loc, is_moving, step_pulse, mx);
            end
        end
        pulse_frame(8'h00); model_tick(8'h00);
        asserts++;
        if ({Ball_X_Loc, Ball_Y_Loc, is_moving} !== {10'(mx), 10'(my), 1'b0} || tk_pulses !== 0) begin
            fails++;
            $display("FAIL glitch_tick: got x=%0d y=%0d mv=%b p=%0d, expected x=%0d y=%0d mv=0 p=0",
                     Ball_X_Loc, Ball_Y_Loc, is_moving, tk_pulses, mx, my);
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0:       k = 8'h1A;
                1:       k = 8'h16;
                2:       k = 8'h04;
                3, 4:    k = 8'h07;
                5:       k = 8'h00;
                default: k = 8'($urandom);
            endcase
            pulse_frame(k);
            model_tick(k);
            asserts++;
            if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving} !== {10'(mx), 10'(my), 2'(mface), mmov}) begin
                fails++;
                $display("FAIL random %0d key=%h: got x=%0d y=%0d f=%b mv=%b, expected x=%0d y=%0d f=%0d mv=%0d",
                         i, k, Ball_X_Loc, Ball_Y_Loc, facing, is_moving, mx, my, mface, mmov);
            end
            asserts++;
            if (tk_pulses !== int'(m_moved) || (m_moved && tk_first !== 3)) begin
                fails++;
                $display("FAIL random_pulse %0d: got pulses=%0d at cycle %0d, expected %0d at cycle 3",
                         i, tk_pulses, tk_first, m_moved);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        for (int guard = 0; guard < 40 && mx != 300; guard++) begin
            pulse_frame(8'h07);
            model_tick(8'h07);
        end
        asserts++;
        if (Ball_X_Loc !== 10'd300 || is_moving !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: got x=%0d mv=%b, expected 300 1", Ball_X_Loc, is_moving);
        end
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        asserts++;
        if ({Ball_X_Loc, Ball_Y_Loc, facing, is_moving} !== {10'd240, 10'd96, 2'b11, 1'b0}) begin
            fails++;
            $display("FAIL midreset_async: got x=%0d y=%0d f=%b mv=%b, expected 240 96 11 0",
                     Ball_X_Loc, Ball_Y_Loc, facing, is_moving);
        end
        frame_clk = 1'b1;
        keycode   = 8'h07;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        tk_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk);
            #1;
            if (step_pulse === 1'b1) tk_pulses++;
        end
        asserts++;
        if (tk_pulses !== 0 || Ball_X_Loc !== 10'd240 || is_moving !== 1'b0) begin
            fails++;
            $display("FAIL high_at_release: got pulses=%0d x=%0d mv=%b, expected 0 240 0",
                     tk_pulses, Ball_X_Loc, is_moving);
        end
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        model_reset();
        pulse_frame(8'h07);
        model_tick(8'h07);
        asserts++;
        if ({Ball_X_Loc, is_moving} !== {10'(mx), mmov} || tk_pulses !== 1 || tk_first !== 3) begin
            fails++;
            $display("FAIL first_after_reset: got x=%0d mv=%b p=%0d at %0d, expected x=%0d mv=1 p=1 at 3",
                     Ball_X_Loc, is_moving, tk_pulses, tk_first, mx);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        model_reset();
        test_reset();
        test_walk_right();
        test_turn_unaligned();
        test_reverse();
        test_bounds();
        test_stop_and_glitch();
        test_random();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/digger_motion.md
DIGGER_MOTION -- requirements
Module: digger_motion

Interface
REQ-001 Parameter STEP, default 2: pixels moved per frame tick; legal values 1, 2, 4, 8 (divisors of 16).
REQ-002 Parameter START_X, default 10'd240: digger X position after reset.
REQ-003 Parameter START_Y, default 10'd96: digger Y position after reset.
REQ-004 Clk  input  1  system clock; one clock; reset is asynchronous and active-low.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 frame_clk  input  1  vertical-sync-rate strobe, asynchronous to Clk, level signal.
REQ-007 keycode  input  8  current HID keycode: 0x1A up (W), 0x16 down (S), 0x04 left (A), 0x07 right (D); any other value means no request.
REQ-008 Ball_X_Loc  output  10  sprite top-left X in pixels; registered.
REQ-009 Ball_Y_Loc  output  10  sprite top-left Y in pixels; registered.
REQ-010 facing  output  2  current direction: 00 up, 01 down, 10 left, 11 right; registered.
REQ-011 is_moving  output  1  high while in the MOVE state.
REQ-012 step_pulse  output  1  one-Clk pulse on every cycle in which Ball_X_Loc or Ball_Y_Loc changes.

Function
REQ-013 frame_clk SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL produce a 1-cycle internal tick.
REQ-014 Tick latency: the tick SHALL assert exactly 1 Clk after the synchronized signal goes high; a position update SHALL be registered on that tick edge.
REQ-015 States: IDLE and MOVE.
REQ-016 State transitions SHALL be evaluated only on tick cycles.
REQ-017 IDLE -> MOVE on a tick with a valid key request.
REQ-018 MOVE -> IDLE on a tick with no valid request, with no step taken on that tick.
REQ-019 On the IDLE -> MOVE tick, the requested direction SHALL be adopted immediately and one step taken, subject to REQ-021 to REQ-024.
REQ-020 Aligned: Ball_X_Loc[3:0]==0 when the travel axis is horizontal; Ball_Y_Loc[3:0]==0 when it is vertical.
REQ-021 Request equal to the current direction: step STEP pixels in that direction.
REQ-022 Reverse request (opposite direction, same axis): adopt the new direction and step at once, aligned or not.
REQ-023 Perpendicular request when aligned: adopt the new direction and step along the new axis on the same tick.
REQ-024 Perpendicular request when not aligned: keep the current direction and step along it; the turn occurs on the first tick at which the position is aligned.
REQ-025 Bounds: X in [0, 496], Y in [96, 464] (32x24 tiles of 16 px).
REQ-026 A step that would leave the bounds SHALL be clamped to the bound; no step_pulse if the position is unchanged.
REQ-027 State remains MOVE while blocked at a bound, and facing still updates.
REQ-028 Arithmetic SHALL be unsigned 10-bit; below-minimum results (Y<96, X underflow) SHALL be detected before subtraction, never by wraparound.
REQ-029 Since STEP divides 16 and the start position is aligned, position SHALL stay a multiple of STEP on both axes.
REQ-030 keycode SHALL be sampled only on the tick cycle; changes between ticks have no effect.
REQ-031 On non-tick cycles all outputs SHALL hold, and step_pulse = 0.

Reset
REQ-032 While Reset=0, asynchronously: Ball_X_Loc=START_X, Ball_Y_Loc=START_Y, facing=11, is_moving=0, step_pulse=0, state=IDLE, synchronizer flops=0.
REQ-033 Reset asserted mid-move SHALL abort the move; after release, the first rising frame_clk edge SHALL be treated normally.
REQ-034 A frame_clk already high at reset release SHALL NOT create a tick.

Verification
REQ-035 Reset, keycode=0x07, 3 frame_clk edges -> X 240->242->244->246, Y=96, facing=11, 3 step_pulses, each 2 Clk after a frame_clk rise.
REQ-036 At X=244, Y=96 moving right, keycode=0x16 -> ticks give X=246, 248, 250, 252, 254, 256, then Y=98 with X=256, facing=01.
REQ-037 At X=250 moving right, keycode=0x04 -> next tick X=248, facing=10 (immediate reversal).
REQ-038 At X=494, keycode=0x07 -> ticks give X=496, then 496 with no step_pulse; is_moving stays 1. At Y=96, keycode=0x1A -> Y stays 96 (no wrap).
REQ-039 Moving, keycode=0x00 at a tick -> is_moving=0, no step. keycode toggled between ticks -> no effect.
REQ-040 Reset pulled low while moving at X=300 -> outputs return immediately to 240/96/11/0; frame_clk held high through release -> no tick until its next rising edge.
